// File: rtl/soc_sram_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : soc_sram_responder_pkg
// Description : Shared constants, MMIO register select type and byte-merge helper
// Revision    : 1.0 - initial release
// ============================================================================
package soc_sram_responder_pkg;

    localparam int          RAM_WORD_W        = 32;
    localparam logic [31:0] DEFAULT_CONF_BASE = 32'hBFAF_0000;

    localparam logic [15:0] OFF_LED    = 16'h0000;
    localparam logic [15:0] OFF_SWITCH = 16'h0004;
    localparam logic [15:0] OFF_TIMER  = 16'h0008;

    typedef enum logic [1:0] {
        SEL_LED    = 2'd0,
        SEL_SWITCH = 2'd1,
        SEL_TIMER  = 2'd2,
        SEL_NONE   = 2'd3
    } mmio_sel_e;

    function automatic mmio_sel_e decode_offset(input logic [15:0] off);
        mmio_sel_e sel;
        sel = SEL_NONE;
        case (off)
            OFF_LED:    sel = SEL_LED;
            OFF_SWITCH: sel = SEL_SWITCH;
            OFF_TIMER:  sel = SEL_TIMER;
            default:    sel = SEL_NONE;
        endcase
        return sel;
    endfunction

    function automatic logic [RAM_WORD_W-1:0] byte_merge(
        input logic [RAM_WORD_W-1:0] old_word,
        input logic [RAM_WORD_W-1:0] new_word,
        input logic [3:0]            be
    );
        logic [RAM_WORD_W-1:0] res;
        res = old_word;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[i*8 +: 8] = new_word[i*8 +: 8];
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soc_sram_responder_sram_bank.sv
`default_nettype none
// ============================================================================
// Module      : soc_sram_responder_sram_bank
// Description : True dual-port read-first word RAM; port A read-only, port B byte-write
// Revision    : 1.0 - initial release
// ============================================================================
module soc_sram_responder_sram_bank
    import soc_sram_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  a_en,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    output logic [RAM_WORD_W-1:0] a_rdata,
    input  logic                  b_en,
    input  logic [3:0]            b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [RAM_WORD_W-1:0] b_wdata,
    output logic [RAM_WORD_W-1:0] b_rdata
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [RAM_WORD_W-1:0] r_mem [0:DEPTH-1];
    logic [RAM_WORD_W-1:0] r_a_rdata;
    logic [RAM_WORD_W-1:0] r_b_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_rdata <= '0;
        end else if (a_en) begin
            r_a_rdata <= r_mem[a_addr];
        end
    end

    // Port B output only moves on reads so a write leaves the last read word visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_b_rdata <= '0;
        end else if (b_en && (b_we == 4'b0000)) begin
            r_b_rdata <= r_mem[b_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && b_en) begin
            for (int i = 0; i < 4; i++) begin
                if (b_we[i]) r_mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
            end
        end
    end

    assign a_rdata = r_a_rdata;
    assign b_rdata = r_b_rdata;

endmodule
`default_nettype wire

// File: rtl/soc_sram_responder.sv
`default_nettype none
// ============================================================================
// Module      : soc_sram_responder
// Description : Inst/data SRAM responder with shared RAM and LED/switch/timer MMIO
// Revision    : 1.0 - initial release
// ============================================================================
module soc_sram_responder
    import soc_sram_responder_pkg::*;
#(
    parameter int          ADDR_WIDTH = 16,
    parameter logic [31:0] CONF_BASE  = DEFAULT_CONF_BASE
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    input  logic [15:0] switch
);

    logic        w_is_mmio;
    logic        w_data_rd;
    logic        w_data_wr;
    mmio_sel_e   w_sel;
    logic [31:0] w_mmio_rdata;
    logic [31:0] w_led_merged;
    logic [31:0] w_ram_rdata;
    logic        w_unused;

    logic [15:0] r_led;
    logic [31:0] r_timer;
    logic [15:0] r_sync1;
    logic [15:0] r_sync2;
    logic        r_rd_mmio;
    logic [31:0] r_mmio_rdata;

    assign w_is_mmio    = (data_sram_addr[31:16] == CONF_BASE[31:16]);
    assign w_data_rd    = data_sram_en && (data_sram_we == 4'b0000);
    assign w_data_wr    = data_sram_en && (data_sram_we != 4'b0000) && w_is_mmio;
    assign w_sel        = decode_offset(data_sram_addr[15:0]);
    assign w_led_merged = byte_merge({16'b0, r_led}, data_sram_wdata, {2'b00, data_sram_we[1:0]});

    soc_sram_responder_sram_bank #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clk     (clk),
        .reset   (reset),
        .a_en    (inst_sram_en),
        .a_addr  (inst_sram_addr[ADDR_WIDTH+1:2]),
        .a_rdata (inst_sram_rdata),
        .b_en    (data_sram_en && !w_is_mmio),
        .b_we    (data_sram_we),
        .b_addr  (data_sram_addr[ADDR_WIDTH+1:2]),
        .b_wdata (data_sram_wdata),
        .b_rdata (w_ram_rdata)
    );

    always_comb begin
        w_mmio_rdata = '0;
        case (w_sel)
            SEL_LED:    w_mmio_rdata = {16'b0, r_led};
            SEL_SWITCH: w_mmio_rdata = {16'b0, r_sync2};
            SEL_TIMER:  w_mmio_rdata = r_timer;
            default:    w_mmio_rdata = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_led <= '0;
        end else if (w_data_wr && (w_sel == SEL_LED)) begin
            r_led <= w_led_merged[15:0];
        end
    end

    // A software load takes priority over the free-running increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_timer <= '0;
        end else if (w_data_wr && (w_sel == SEL_TIMER)) begin
            r_timer <= byte_merge(r_timer, data_sram_wdata, data_sram_we);
        end else begin
            r_timer <= r_timer + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= switch;
            r_sync2 <= r_sync1;
        end
    end

    // MMIO read data is captured at the access edge so it matches RAM latency.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_mmio    <= 1'b0;
            r_mmio_rdata <= '0;
        end else if (w_data_rd) begin
            r_rd_mmio <= w_is_mmio;
            if (w_is_mmio) r_mmio_rdata <= w_mmio_rdata;
        end
    end

    assign data_sram_rdata = r_rd_mmio ? r_mmio_rdata : w_ram_rdata;
    assign led             = r_led;

    assign w_unused = ^{inst_sram_we, inst_sram_wdata,
                        inst_sram_addr[31:ADDR_WIDTH+2], inst_sram_addr[1:0]};

endmodule
`default_nettype wire
